// File: rtl/cam_config_sequencer.sv
// cam_config_sequencer: camera reset/power-up sequencing and SCCB register-table walker.
module cam_config_sequencer #(
  parameter int NUM_ENTRIES    = 64,
  parameter int RST_CYCLES     = 2500,
  parameter int PWR_CYCLES     = 250000,
  parameter int DELAY_CYCLES   = 250000,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRIES    = 3,
  localparam int AW = $clog2(NUM_ENTRIES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  output logic          sccb_start,
  output logic [7:0]    sccb_reg_addr,
  output logic [7:0]    sccb_reg_data,
  input  logic          sccb_done,
  input  logic          sccb_ack_err,
  output logic          cam_reset_n,
  output logic          cam_pwdn,
  output logic          busy,
  output logic          config_done,
  output logic          config_err,
  output logic [AW-1:0] err_index
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int PW = $clog2(PWR_CYCLES + 1);
  localparam int DW = $clog2(DELAY_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int MW = MAX_RETRIES > 0 ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [PW-1:0] PWR_LAST = PW'(PWR_CYCLES - 1);
  localparam logic [DW-1:0] DLY_LAST = DW'(DELAY_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [MW-1:0] RET_MAX  = MW'(MAX_RETRIES);
  localparam logic [AW-1:0] IDX_LAST = AW'(NUM_ENTRIES - 1);
  typedef enum logic [3:0] {
    IDLE, CAM_RST, PWR_WAIT, FETCH, DECODE, ISSUE, WAIT_DONE, DELAY, DONE, ERROR
  } state_t;
  state_t state, state_n;
  logic [AW-1:0] idx, idx_n, eidx, eidx_n;
  logic [7:0] ra, ra_n, rd, rd_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [MW-1:0] ret, ret_n;
  logic pwdn, pwdn_n, adv, last;
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      eidx  <= '0;
      ra    <= '0;
      rd    <= '0;
      rcnt  <= '0;
      pcnt  <= '0;
      dcnt  <= '0;
      tcnt  <= '0;
      ret   <= '0;
      pwdn  <= 1'b1;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      eidx  <= eidx_n;
      ra    <= ra_n;
      rd    <= rd_n;
      rcnt  <= rcnt_n;
      pcnt  <= pcnt_n;
      dcnt  <= dcnt_n;
      tcnt  <= tcnt_n;
      ret   <= ret_n;
      pwdn  <= pwdn_n;
    end
  // Counters run only inside their own state, so they are zero on every entry.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    eidx_n  = eidx;
    ra_n    = ra;
    rd_n    = rd;
    ret_n   = ret;
    pwdn_n  = pwdn;
    adv     = 1'b0;
    last    = idx == IDX_LAST;
    rcnt_n  = state == CAM_RST   ? rcnt + 1'b1 : '0;
    pcnt_n  = state == PWR_WAIT  ? pcnt + 1'b1 : '0;
    dcnt_n  = state == DELAY     ? dcnt + 1'b1 : '0;
    tcnt_n  = state == WAIT_DONE ? tcnt + 1'b1 : '0;
    case (state)
      IDLE, DONE, ERROR:
        if (start) begin
          state_n = CAM_RST;
          idx_n   = '0;
          ret_n   = '0;
          pwdn_n  = 1'b0;
        end
      CAM_RST:  state_n = rcnt == RST_LAST ? PWR_WAIT : CAM_RST;
      PWR_WAIT: state_n = pcnt == PWR_LAST ? FETCH : PWR_WAIT;
      FETCH:    state_n = DECODE;
      DECODE: begin
        state_n = rom_data == 16'hFFFF ? DONE : rom_data == 16'hFFF0 ? DELAY : ISSUE;
        if (state_n == ISSUE) {ra_n, rd_n} = rom_data;
      end
      ISSUE:    state_n = WAIT_DONE;
      WAIT_DONE:
        if (sccb_done && !sccb_ack_err) adv = 1'b1;
        else if (sccb_done || tcnt == TO_LAST) begin
          if (ret < RET_MAX) begin
            ret_n   = ret + 1'b1;
            state_n = ISSUE;
          end else begin
            eidx_n  = idx;
            state_n = ERROR;
          end
        end
      DELAY:    adv = dcnt == DLY_LAST;
      default: ;
    endcase
    // The index saturates at the last entry so rom_addr never wraps back to 0.
    if (adv) begin
      ret_n   = '0;
      idx_n   = last ? idx : idx + 1'b1;
      state_n = last ? DONE : FETCH;
    end
  end
  assign rom_addr      = idx;
  assign err_index     = eidx;
  assign sccb_reg_addr = ra;
  assign sccb_reg_data = rd;
  assign sccb_start    = state == ISSUE;
  assign cam_reset_n   = state != CAM_RST;
  assign cam_pwdn      = pwdn;
  assign busy          = !(state inside {IDLE, DONE, ERROR});
  assign config_done   = state == DONE;
  assign config_err    = state == ERROR;
endmodule

// File: tb/tb_cam_config_sequencer.sv
// tb_cam_config_sequencer: directed scenarios against a 1-cycle-latency ROM and an SCCB master model.
module tb_cam_config_sequencer;
  logic clk = 1'b0;
  logic reset, start;
  logic [2:0] rom_addr, err_index;
  logic [15:0] rom_data;
  logic sccb_start, sccb_done, sccb_ack_err;
  logic [7:0] sccb_reg_addr, sccb_reg_data;
  logic cam_reset_n, cam_pwdn, busy, config_done, config_err;
  logic [15:0] rom [8];
  int vectors = 0, miscompares = 0;
  int cyc = 0, starts = 0, dones = 0, dly = 0;
  int nack_lo = 0, nack_hi = 0;
  logic nack_q = 1'b0;
  logic [3:0] silent = 4'hF;
  logic [15:0] log_w [64];
  int log_c [64], done_c [64];

  cam_config_sequencer #(
    .NUM_ENTRIES(8), .RST_CYCLES(4), .PWR_CYCLES(8), .DELAY_CYCLES(10),
    .TIMEOUT_CYCLES(20), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb_start(sccb_start), .sccb_reg_addr(sccb_reg_addr), .sccb_reg_data(sccb_reg_data),
    .sccb_done(sccb_done), .sccb_ack_err(sccb_ack_err), .cam_reset_n(cam_reset_n),
    .cam_pwdn(cam_pwdn), .busy(busy), .config_done(config_done), .config_err(config_err),
    .err_index(err_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  // SCCB master: done 5 cycles after each start; NACK on start numbers in [nack_lo, nack_hi);
  // never answers a write issued while rom_addr equals silent.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    sccb_done <= 1'b0;
    sccb_ack_err <= 1'b0;
    if (sccb_done) begin
      done_c[dones] <= cyc;
      dones <= dones + 1;
    end
    if (sccb_start) begin
      log_w[starts] <= {sccb_reg_addr, sccb_reg_data};
      log_c[starts] <= cyc;
      starts <= starts + 1;
      nack_q <= starts >= nack_lo && starts < nack_hi;
      dly <= {1'b0, rom_addr} == silent ? 0 : 4;
    end else if (dly > 0) begin
      dly <= dly - 1;
      if (dly == 1) begin
        sccb_done <= 1'b1;
        sccb_ack_err <= nack_q;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget && busy; k++) @(negedge clk);
    vectors++;
    if (busy) begin
      miscompares++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, want 0", busy, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({cam_reset_n, cam_pwdn, sccb_start, busy, config_done, config_err} !== 6'b110000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 110000",
               {cam_reset_n, cam_pwdn, sccb_start, busy, config_done, config_err});
    end
    vectors++;
    if ({rom_addr, err_index, sccb_reg_addr, sccb_reg_data} !== 22'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want 0", {rom_addr, err_index, sccb_reg_addr, sccb_reg_data});
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cam_pwdn, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL idle_hold: pwdn,busy got %b want 10", {cam_pwdn, busy});
    end
  endtask

  task automatic test_nominal();
    int s0, d0, low;
    rom = '{16'h1280, 16'h1204, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    s0 = starts;
    d0 = dones;
    pulse_start();
    vectors++;
    if ({busy, cam_pwdn} !== 2'b10) begin
      miscompares++;
      $display("FAIL start_busy: busy,pwdn got %b want 10", {busy, cam_pwdn});
    end
    low = 0;
    while (!cam_reset_n && low < 50) begin
      low++;
      @(negedge clk);
    end
    vectors++;
    if (low != 4) begin
      miscompares++;
      $display("FAIL cam_rst_len: got %0d cycles want 4", low);
    end
    wait_idle(400);
    vectors++;
    if (starts - s0 != 2) begin
      miscompares++;
      $display("FAIL nom_writes: got %0d want 2", starts - s0);
    end
    vectors++;
    if (log_w[s0] !== 16'h1280 || log_w[s0+1] !== 16'h1204) begin
      miscompares++;
      $display("FAIL nom_data: got %h,%h want 1280,1204", log_w[s0], log_w[s0+1]);
    end
    vectors++;
    if (log_c[s0+1] - done_c[d0] != 3) begin
      miscompares++;
      $display("FAIL nom_gap: got %0d want 3", log_c[s0+1] - done_c[d0]);
    end
    vectors++;
    if ({config_done, config_err, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL nom_status: got %b want 100", {config_done, config_err, busy});
    end
  endtask

  task automatic test_delay();
    int s0, d0;
    rom = '{16'h1280, 16'hFFF0, 16'h1204, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0};
    s0 = starts;
    d0 = dones;
    pulse_start();
    wait_idle(400);
    vectors++;
    if (starts - s0 != 2 || log_w[s0+1] !== 16'h1204) begin
      miscompares++;
      $display("FAIL dly_writes: got %0d last %h want 2 last 1204", starts - s0, log_w[s0+1]);
    end
    vectors++;
    if (log_c[s0+1] - done_c[d0] != 15) begin
      miscompares++;
      $display("FAIL dly_gap: got %0d want 15", log_c[s0+1] - done_c[d0]);
    end
    vectors++;
    if ({config_done, config_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL dly_status: got %b want 10", {config_done, config_err});
    end
  endtask

  task automatic test_nack_retry();
    int s0;
    rom = '{16'h1280, 16'h1204, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    s0 = starts;
    nack_lo = s0 + 1;
    nack_hi = s0 + 3;
    pulse_start();
    wait_idle(400);
    vectors++;
    if (starts - s0 != 4) begin
      miscompares++;
      $display("FAIL nack_writes: got %0d want 4", starts - s0);
    end
    vectors++;
    if (log_w[s0+1] !== 16'h1204 || log_w[s0+2] !== 16'h1204 || log_w[s0+3] !== 16'h1204) begin
      miscompares++;
      $display("FAIL nack_data: got %h,%h,%h want 1204 x3", log_w[s0+1], log_w[s0+2], log_w[s0+3]);
    end
    vectors++;
    if ({config_done, config_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL nack_status: got %b want 10", {config_done, config_err});
    end
    nack_lo = 0;
    nack_hi = 0;
  endtask

  task automatic test_timeout();
    int s0;
    rom = '{16'h1280, 16'h1204, 16'h1311, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0};
    s0 = starts;
    silent = 4'd2;
    pulse_start();
    wait_idle(600);
    vectors++;
    if (starts - s0 != 5 || log_w[s0+4] !== 16'h1311) begin
      miscompares++;
      $display("FAIL to_writes: got %0d last %h want 5 last 1311", starts - s0, log_w[s0+4]);
    end
    vectors++;
    if (log_c[s0+3] - log_c[s0+2] != 21 || log_c[s0+4] - log_c[s0+3] != 21) begin
      miscompares++;
      $display("FAIL to_spacing: got %0d,%0d want 21,21 (20 wait cycles)",
               log_c[s0+3] - log_c[s0+2], log_c[s0+4] - log_c[s0+3]);
    end
    vectors++;
    if ({config_err, config_done, err_index} !== 5'b10_010) begin
      miscompares++;
      $display("FAIL to_status: err,done,idx got %b want 10010", {config_err, config_done, err_index});
    end
    silent = 4'hF;
    pulse_start();
    vectors++;
    if ({config_err, cam_reset_n, busy} !== 3'b001) begin
      miscompares++;
      $display("FAIL to_restart: err,rst_n,busy got %b want 001", {config_err, cam_reset_n, busy});
    end
    wait_idle(400);
    vectors++;
    if ({config_done, config_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL to_rerun: got %b want 10", {config_done, config_err});
    end
  endtask

  task automatic test_full_table();
    int s0, bad, k;
    logic seen7;
    for (int i = 0; i < 8; i++) rom[i] = 16'h2040 + 16'(i * 257);
    s0 = starts;
    bad = 0;
    seen7 = 1'b0;
    pulse_start();
    for (k = 0; k < 600 && busy; k++) begin
      if (rom_addr == 3'd7) seen7 = 1'b1;
      else if (seen7 && rom_addr == 3'd0) bad++;
      @(negedge clk);
    end
    vectors++;
    if (busy) begin
      miscompares++;
      $display("FAIL full_idle: busy %b want 0", busy);
    end
    vectors++;
    if (starts - s0 != 8 || log_w[s0+7] !== 16'h2747) begin
      miscompares++;
      $display("FAIL full_writes: got %0d last %h want 8 last 2747", starts - s0, log_w[s0+7]);
    end
    vectors++;
    if (bad != 0 || rom_addr !== 3'd7) begin
      miscompares++;
      $display("FAIL full_wrap: wraps %0d addr %0d want 0 and 7", bad, rom_addr);
    end
    vectors++;
    if ({config_done, config_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL full_status: got %b want 10", {config_done, config_err});
    end
  endtask

  task automatic test_mid_run();
    int s0, low, k;
    rom = '{16'h1280, 16'h1204, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    s0 = starts;
    pulse_start();
    for (k = 0; k < 100 && !sccb_start; k++) @(negedge clk);
    vectors++;
    if (!sccb_start) begin
      miscompares++;
      $display("FAIL mid_first_start: sccb_start %b want 1", sccb_start);
    end
    pulse_start();
    low = 0;
    for (k = 0; k < 400 && busy; k++) begin
      if (!cam_reset_n) low++;
      @(negedge clk);
    end
    vectors++;
    if (low != 0 || starts - s0 != 2 || config_done !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_ignored_start: rst_low %0d writes %0d done %b want 0 2 1",
               low, starts - s0, config_done);
    end
    pulse_start();
    for (k = 0; k < 50 && !cam_reset_n; k++) @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({cam_reset_n, cam_pwdn, sccb_start, busy, config_done, config_err} !== 6'b110000) begin
      miscompares++;
      $display("FAIL mid_reset_ctrl: got %b want 110000",
               {cam_reset_n, cam_pwdn, sccb_start, busy, config_done, config_err});
    end
    vectors++;
    if ({rom_addr, err_index, sccb_reg_addr, sccb_reg_data} !== 22'h0) begin
      miscompares++;
      $display("FAIL mid_reset_data: got %h want 0", {rom_addr, err_index, sccb_reg_addr, sccb_reg_data});
    end
    reset = 1'b1;
    s0 = starts;
    repeat (40) @(negedge clk);
    vectors++;
    if (starts != s0 || busy !== 1'b0 || cam_pwdn !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_quiet: writes %0d busy %b pwdn %b want 0 0 1", starts - s0, busy, cam_pwdn);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = 16'hFFFF;
    test_reset();
    test_nominal();
    test_delay();
    test_nack_retry();
    test_timeout();
    test_full_table();
    test_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
